// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//
// Hobby-servo PWM generator. Converts a 10-bit angle command (degrees,
// 0..MAX_ANGLE) into a frame-periodic pulse train whose high time is linearly
// mapped from MIN_PULSE_US (angle 0) to MAX_PULSE_US (angle MAX_ANGLE).
// The command is sampled only at frame boundaries, so every pulse is
// glitch-free and the rising edges are exactly one frame apart.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous reset, active low
//   angle        in   [9:0] commanded angle in degrees, unsigned
//   servo_signal out  registered PWM output
//
// Build option:
//   SERVO_DRIVER_CLAMP_EN  defined  : an out-of-range angle (> MAX_ANGLE)
//                                     latches as MAX_ANGLE.
//                          undefined: an out-of-range angle is rejected and
//                                     the previously latched angle is kept
//                                     (0 after reset).

module servo_pwm_driver #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int PERIOD_US    = 20_000,
  parameter int MIN_PULSE_US = 1_000,
  parameter int MAX_PULSE_US = 2_000,
  parameter int MAX_ANGLE    = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] angle,
  output logic       servo_signal
);

  localparam int US_TICKS = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W    = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
  localparam int CNT_W    = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int SPAN_US  = MAX_PULSE_US - MIN_PULSE_US;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [CNT_W-1:0] us_cnt_reg, us_cnt_next;
  logic [9:0]       angle_reg, angle_next;

  logic             us_tick;
  logic             frame_end;
  logic             pulse_end;
  logic [9:0]       angle_sample;
  logic [31:0]      product;
  logic [31:0]      pulse_us;

  // One-cycle strobe at the prescaler terminal count.
  assign us_tick   = (pre_reg == PRE_W'(US_TICKS - 1));
  assign frame_end = us_tick && (us_cnt_reg == CNT_W'(PERIOD_US - 1));

  // Pulse width from the latched angle. The latched value is always in range,
  // so the result stays within MIN_PULSE_US..MAX_PULSE_US. The divisor is a
  // constant, so this reduces to fixed multiply/shift logic.
  assign product  = 32'(angle_reg) * 32'(SPAN_US);
  assign pulse_us = 32'(MIN_PULSE_US) + product / 32'(MAX_ANGLE);

  // HIGH ends on the tick that would move us_cnt to pulse_us.
  assign pulse_end = us_tick && (32'(us_cnt_reg) == (pulse_us - 32'd1));

  // Value to latch at a frame boundary, with out-of-range handling.
  always_comb begin
    angle_sample = angle;
    if (angle > 10'(MAX_ANGLE)) begin
`ifdef SERVO_DRIVER_CLAMP_EN
      angle_sample = 10'(MAX_ANGLE);
`else
      angle_sample = angle_reg;
`endif
    end
  end

  // Next-state logic. The counters free-run in HIGH and LOW; us_cnt wraps at
  // the frame end, which coincides with the LOW->HIGH transition.
  always_comb begin
    state_next  = state_reg;
    angle_next  = angle_reg;
    pre_next    = us_tick ? '0 : pre_reg + PRE_W'(1);
    us_cnt_next = us_cnt_reg;
    if (us_tick) begin
      us_cnt_next = frame_end ? '0 : us_cnt_reg + CNT_W'(1);
    end

    unique case (state_reg)
      IDLE: begin
        state_next  = HIGH;
        angle_next  = angle_sample;
        pre_next    = '0;
        us_cnt_next = '0;
      end
      HIGH: begin
        if (pulse_end) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (frame_end) begin
          state_next = HIGH;
          angle_next = angle_sample;
        end
      end
      default: begin
        state_next  = IDLE;
        pre_next    = '0;
        us_cnt_next = '0;
      end
    endcase
  end

  // State register. The output is registered from the next state so it
  // changes on the same edge as the state, with no extra cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      pre_reg      <= '0;
      us_cnt_reg   <= '0;
      angle_reg    <= '0;
      servo_signal <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      us_cnt_reg   <= us_cnt_next;
      angle_reg    <= angle_next;
      servo_signal <= (state_next == HIGH);
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Directed testbench for servo_pwm_driver.
// Uses a scaled-down configuration so each frame is short:
//   2 MHz clock (2 cycles per us), 400 us frame, 100..200 us pulse, 180 deg.
// Expected high times in cycles: 0->200, 7->206, 45->250, 90->300, 180->400.
// Frame length: 800 cycles.

module tb_servo_pwm_driver;

  localparam int CLK_FREQ_HZ  = 2_000_000;
  localparam int PERIOD_US    = 400;
  localparam int MIN_PULSE_US = 100;
  localparam int MAX_PULSE_US = 200;
  localparam int MAX_ANGLE    = 180;
  localparam int FRAME_CYC    = 800;

`ifdef SERVO_DRIVER_CLAMP_EN
  localparam int OOR_W = 400;
`else
  localparam int OOR_W = 200;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] angle;
  logic       servo_signal;

  int tests_run;
  int tests_failed;
  int cyc;
  int last_rise;

  servo_pwm_driver #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .PERIOD_US   (PERIOD_US),
    .MIN_PULSE_US(MIN_PULSE_US),
    .MAX_PULSE_US(MAX_PULSE_US),
    .MAX_ANGLE   (MAX_ANGLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .angle       (angle),
    .servo_signal(servo_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Wait (sampling on falling edges) until servo_signal equals lvl.
  task automatic wait_level(input logic lvl, output int at, output bit to);
    to = 1'b1;
    at = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (servo_signal === lvl) begin
        at = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  // From inside a frame that began at last_rise: measure its high time and
  // the distance to the next rising edge, then advance last_rise.
  task automatic measure_frame(output int h, output int p, output bit to);
    int f, r;
    bit t1, t2;
    wait_level(1'b0, f, t1);
    wait_level(1'b1, r, t2);
    h = f - last_rise;
    p = r - last_rise;
    last_rise = r;
    to = t1 | t2;
  endtask

  task automatic test_reset();
    int h, p;
    bit to;
    rst   = 1'b0;
    angle = 10'd180;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (servo_signal !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_low[%0d]: servo_signal=%b expected 0", i, servo_signal);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (servo_signal !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_rise: servo_signal=%b expected 1", servo_signal);
    end
    last_rise = cyc;
    measure_frame(h, p, to);
    tests_run++;
    if (to || h !== 400) begin
      tests_failed++;
      $display("FAIL reset_high_180: high=%0d timeout=%0b expected 400", h, to);
    end
    tests_run++;
    if (to || p !== FRAME_CYC) begin
      tests_failed++;
      $display("FAIL reset_period: period=%0d expected %0d", p, FRAME_CYC);
    end
    $display("[TB] reset: high=%0d period=%0d", h, p);
  endtask

  // Each new angle is applied one cycle into a frame, so the frame being
  // measured still uses the previously latched angle.
  task automatic test_angle_sweep();
    int angles[6] = '{0, 90, 45, 7, 180, 0};
    int widths[6] = '{200, 300, 250, 206, 400, 200};
    int prev_w;
    int h, p;
    bit to;
    prev_w = 400;
    for (int i = 0; i < 6; i++) begin
      angle = 10'(angles[i]);
      measure_frame(h, p, to);
      tests_run++;
      if (to || h !== prev_w) begin
        tests_failed++;
        $display("FAIL sweep_high[%0d]: high=%0d timeout=%0b expected %0d", i, h, to, prev_w);
      end
      tests_run++;
      if (to || p !== FRAME_CYC) begin
        tests_failed++;
        $display("FAIL sweep_period[%0d]: period=%0d expected %0d", i, p, FRAME_CYC);
      end
      $display("[TB] sweep: new angle=%0d, frame high=%0d period=%0d", angles[i], h, p);
      prev_w = widths[i];
    end
  endtask

  task automatic test_mid_frame();
    int h, p;
    bit to;
    // Current frame latched 0 (200 cycles high); change inside the pulse.
    for (int i = 0; i < 100; i++) @(negedge clk);
    angle = 10'd180;
    measure_frame(h, p, to);
    tests_run++;
    if (to || h !== 200) begin
      tests_failed++;
      $display("FAIL mid_frame_current: high=%0d expected 200", h);
    end
    measure_frame(h, p, to);
    tests_run++;
    if (to || h !== 400 || p !== FRAME_CYC) begin
      tests_failed++;
      $display("FAIL mid_frame_next: high=%0d period=%0d expected 400/%0d", h, p, FRAME_CYC);
    end
    $display("[TB] mid_frame: next high=%0d period=%0d", h, p);
  endtask

  task automatic test_out_of_range();
    int h, p;
    bit to;
    angle = 10'd0;
    measure_frame(h, p, to);   // finishes the 180 frame; 0 now latched
    tests_run++;
    if (to || h !== 400) begin
      tests_failed++;
      $display("FAIL oor_setup: high=%0d expected 400", h);
    end
    angle = 10'd500;
    measure_frame(h, p, to);
    tests_run++;
    if (to || h !== 200) begin
      tests_failed++;
      $display("FAIL oor_current: high=%0d expected 200", h);
    end
    for (int i = 0; i < 2; i++) begin
      measure_frame(h, p, to);
      tests_run++;
      if (to || h !== OOR_W || p !== FRAME_CYC) begin
        tests_failed++;
        $display("FAIL oor_frame[%0d]: high=%0d period=%0d expected %0d/%0d",
                 i, h, p, OOR_W, FRAME_CYC);
      end
      $display("[TB] out_of_range: angle=500 high=%0d period=%0d", h, p);
    end
  endtask

  task automatic test_reset_mid_high();
    int h, p;
    bit to;
    for (int i = 0; i < 50; i++) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (servo_signal !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_low[%0d]: servo_signal=%b expected 0", i, servo_signal);
      end
    end
    angle = 10'd90;
    rst   = 1'b1;
    @(negedge clk);
    tests_run++;
    if (servo_signal !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_rise: servo_signal=%b expected 1", servo_signal);
    end
    last_rise = cyc;
    measure_frame(h, p, to);
    tests_run++;
    if (to || h !== 300 || p !== FRAME_CYC) begin
      tests_failed++;
      $display("FAIL midreset_frame: high=%0d period=%0d expected 300/%0d", h, p, FRAME_CYC);
    end
    $display("[TB] reset_mid_high: fresh high=%0d period=%0d", h, p);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_rise    = 0;
    rst          = 1'b0;
    angle        = 10'd0;
    test_reset();
    test_angle_sweep();
    test_mid_frame();
    test_out_of_range();
    test_reset_mid_high();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
